sched_cmd_arb: RTL and testbench
================================

# sched_cmd_arb

Arbitrates scheduler commands from three TCP engine sources onto the single command port of the flow scheduler state table: app send path (data pending), RX engine (ACK pending) and retransmit timer (RT pending). Round-robin selects one flow per cycle. Concurrent requests naming the same flowid are merged into one `sched_cmd_struct`, each source filling only its own field. The result goes into a one-deep registered output stage with valid/ready handshake.

## Interface
- No parameters. Widths come from `tcp_pkg` (`FLOWID_W`, `TIMESTAMP_W`). `sched_cmd_struct` and the `NOP`/`SET`/`CLEAR` command enum come from `tcp_misc_pkg`.
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_req_val` / `data_req_rdy`  in / out  1 each  app send-path request handshake.
- `data_req_flowid`  in  FLOWID_W  flow with new data pending.
- `ack_req_val` / `ack_req_rdy`  in / out  1 each  RX engine request handshake.
- `ack_req_flowid`  in  FLOWID_W  flow for the ACK-pending command.
- `ack_req_cmd`  in  enum  command applied to the ACK-pending bit.
- `ack_req_ts`  in  TIMESTAMP_W  timestamp for the ACK-pending bit.
- `rt_req_val` / `rt_req_rdy`  in / out  1 each  retransmit-timer request handshake.
- `rt_req_flowid`  in  FLOWID_W  flow for the RT-pending command.
- `rt_req_cmd`  in  enum  command applied to the RT-pending bit.
- `rt_req_ts`  in  TIMESTAMP_W  timestamp for the RT-pending bit.
- `sched_cmd_val`  out  1  registered command valid.
- `sched_cmd`  out  sched_cmd_struct  registered command.
- `sched_cmd_rdy`  in  1  scheduler accepts the command.

## Operation
- Source indices: 0 = data, 1 = ack, 2 = rt. `rr_ptr` (2 bits, values 0–2) marks the highest-priority source.
- Capture is allowed when `load_en = !sched_cmd_val | sched_cmd_rdy`.
- Winner: the first valid source found scanning from `rr_ptr` in order `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` (mod 3).
- Merge set: the winner plus every other valid source whose flowid equals the winner's flowid.
- When `load_en` is high and some source is valid:
  - Every source in the merge set sees `rdy=1` in that cycle. All others see `rdy=0`.
  - The output register loads `flowid` = winner flowid.
  - Data field: `{SET, 0}` if source 0 is in the merge set, otherwise `{NOP, 0}`.
  - ACK field: `{ack_req_cmd, ack_req_ts}` if source 1 is merged, otherwise `{NOP, 0}`.
  - RT field: the same rule using the rt inputs.
  - All other struct bits are 0.
  - `rr_ptr` becomes (winner+1) mod 3. Merged non-winners do not affect the pointer.
- When `load_en` is low, all `*_req_rdy` = 0 and `rr_ptr` holds.
- `rdy` is combinational from `val`s, flowids, `rr_ptr`, `sched_cmd_val` and `sched_cmd_rdy`. No source's `rdy` may depend on its own `val`, except that a source in the merge set is granted only while its `val` is high.
- Sources must hold val/payload stable until accepted. The block does not check this.

## Timing
- Reset values: `sched_cmd_val`=0, `sched_cmd`='0, `rr_ptr`=0. The `*_req_rdy` outputs are combinational and read 0 whenever no grant is possible.
- Latency: a request accepted in cycle N appears on `sched_cmd` in cycle N+1.
- Throughput: one command per cycle while `sched_cmd_rdy` stays high.
- Output full with `sched_cmd_rdy`=0: nothing is accepted and the register holds.
- Output full with `sched_cmd_rdy`=1: drain and load happen in the same cycle. There is no bubble.
- Output empty and no requests: `sched_cmd_val` goes to 0 on the next edge.
- Fairness: a continuously valid source waits at most 2 other grants.
- Reset asserted mid-transfer: the output is dropped immediately (async). Any requests not yet accepted remain with their sources.

## Structure
- Put the three source-index localparams (0/1/2) in `tcp_misc_pkg`, next to `sched_cmd_struct`.
- One natural sub-module, `rr_arb_3`: round-robin pointer with one-hot grant. Inputs are the req vector and an advance enable; output is the one-hot grant. Flowid compare, merge and the output register stay in `sched_cmd_arb`.

## Test plan
- Reset, then data req flowid=5 alone, `sched_cmd_rdy`=1 → next cycle `sched_cmd_val`=1, flowid 5, data=SET, ack=NOP, rt=NOP; `rr_ptr`=1.
- All three valid, flowids 1/2/3, `rr_ptr`=0, rdy held at 1 → outputs in order flowid 1 (data), 2 (ack), 3 (rt) on consecutive cycles.
- Data flowid 7 and ack flowid 7 (cmd SET, ts 0x40) valid together → one output: flowid 7, data SET, ack {SET, 0x40}, rt NOP. Both rdys high in the same cycle.
- `sched_cmd_rdy`=0 for 4 cycles with the output full and rt valid → rt_req_rdy stays 0 and the output is unchanged. When rdy rises, the old command drains and the rt command loads in that same cycle.
- rt CLEAR flowid 9 ts 0x1234 with ack flowid 9 and data flowid 4, `rr_ptr`=2 → first output flowid 9 with ack+rt merged; next output flowid 4 data SET.
- `rst_n` pulled low while `sched_cmd_val`=1 → `sched_cmd_val`=0 immediately. After release, the first grant goes to source 0.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// rtl/tcp_misc_pkg.sv - scheduler command types and source indices
package tcp_misc_pkg;
  import tcp_pkg::*;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    SET   = 2'd1,
    CLEAR = 2'd2
  } sched_cmd_e;

  typedef struct packed {
    sched_cmd_e             cmd;
    logic [TIMESTAMP_W-1:0] ts;
  } sched_field_t;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    sched_field_t        data;
    sched_field_t        ack;
    sched_field_t        rt;
  } sched_cmd_struct;

  localparam int SRC_DATA = 0;
  localparam int SRC_ACK  = 1;
  localparam int SRC_RT   = 2;

  // Modulo-3 increment over the source index space
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - TCP engine width constants
package tcp_pkg;
  localparam int FLOWID_W    = 8;
  localparam int TIMESTAMP_W = 16;
endpackage

// File: rtl/sched_cmd_arb_rr_arb_3.sv
// rtl/sched_cmd_arb_rr_arb_3.sv - three-way round-robin arbiter with one-hot grant
module rr_arb_3
  import tcp_misc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic       adv_i,
  output logic [2:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx, win;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
      idx = inc3(idx);
    end
    ptr_d = ptr_q;
    if (adv_i && found) ptr_d = inc3(win);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sched_cmd_arb.sv
// rtl/sched_cmd_arb.sv - merges data/ack/rt scheduler requests onto one registered command port
module sched_cmd_arb
  import tcp_pkg::*, tcp_misc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_req_val,
  output logic                   data_req_rdy,
  input  logic [FLOWID_W-1:0]    data_req_flowid,
  input  logic                   ack_req_val,
  output logic                   ack_req_rdy,
  input  logic [FLOWID_W-1:0]    ack_req_flowid,
  input  sched_cmd_e             ack_req_cmd,
  input  logic [TIMESTAMP_W-1:0] ack_req_ts,
  input  logic                   rt_req_val,
  output logic                   rt_req_rdy,
  input  logic [FLOWID_W-1:0]    rt_req_flowid,
  input  sched_cmd_e             rt_req_cmd,
  input  logic [TIMESTAMP_W-1:0] rt_req_ts,
  output logic                   sched_cmd_val,
  output sched_cmd_struct        sched_cmd,
  input  logic                   sched_cmd_rdy
);

  logic [2:0]          req, gnt, merge;
  logic                load_en, grant_ok;
  logic [FLOWID_W-1:0] fid [3];
  logic [FLOWID_W-1:0] win_fid;
  logic                val_q, val_d;
  sched_cmd_struct     cmd_q, cmd_d;

  assign req     = {rt_req_val, ack_req_val, data_req_val};
  assign fid[0]  = data_req_flowid;
  assign fid[1]  = ack_req_flowid;
  assign fid[2]  = rt_req_flowid;
  assign load_en = !val_q || sched_cmd_rdy;
  // No handshake completes while reset holds the output register
  assign grant_ok = load_en && rst_n;

  rr_arb_3 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .adv_i (grant_ok),
    .gnt_o (gnt)
  );

  always_comb begin
    win_fid = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) win_fid = fid[i];
    end
    for (int i = 0; i < 3; i++) begin
      merge[i] = grant_ok && req[i] && (|gnt) && (fid[i] == win_fid);
    end
  end

  assign data_req_rdy = merge[SRC_DATA];
  assign ack_req_rdy  = merge[SRC_ACK];
  assign rt_req_rdy   = merge[SRC_RT];

  always_comb begin
    cmd_d        = '0;
    cmd_d.flowid = win_fid;
    if (merge[SRC_DATA]) cmd_d.data.cmd = SET;
    if (merge[SRC_ACK]) begin
      cmd_d.ack.cmd = ack_req_cmd;
      cmd_d.ack.ts  = ack_req_ts;
    end
    if (merge[SRC_RT]) begin
      cmd_d.rt.cmd = rt_req_cmd;
      cmd_d.rt.ts  = rt_req_ts;
    end
    val_d = load_en ? (|req) : val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      val_q <= val_d;
      if (load_en && (|req)) cmd_q <= cmd_d;
    end
  end

  assign sched_cmd_val = val_q;
  assign sched_cmd     = cmd_q;

endmodule

// File: tb/tb_sched_cmd_arb.sv
// tb/tb_sched_cmd_arb.sv - randomized bench with behavioural arbitration model
module tb_sched_cmd_arb;
  import tcp_pkg::*;
  import tcp_misc_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   data_req_val, data_req_rdy;
  logic [FLOWID_W-1:0]    data_req_flowid;
  logic                   ack_req_val, ack_req_rdy;
  logic [FLOWID_W-1:0]    ack_req_flowid;
  sched_cmd_e             ack_req_cmd;
  logic [TIMESTAMP_W-1:0] ack_req_ts;
  logic                   rt_req_val, rt_req_rdy;
  logic [FLOWID_W-1:0]    rt_req_flowid;
  sched_cmd_e             rt_req_cmd;
  logic [TIMESTAMP_W-1:0] rt_req_ts;
  logic                   sched_cmd_val;
  sched_cmd_struct        sched_cmd;
  logic                   sched_cmd_rdy;

  always #5 clk = ~clk;

  sched_cmd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_val(data_req_val), .data_req_rdy(data_req_rdy), .data_req_flowid(data_req_flowid),
    .ack_req_val(ack_req_val), .ack_req_rdy(ack_req_rdy), .ack_req_flowid(ack_req_flowid),
    .ack_req_cmd(ack_req_cmd), .ack_req_ts(ack_req_ts),
    .rt_req_val(rt_req_val), .rt_req_rdy(rt_req_rdy), .rt_req_flowid(rt_req_flowid),
    .rt_req_cmd(rt_req_cmd), .rt_req_ts(rt_req_ts),
    .sched_cmd_val(sched_cmd_val), .sched_cmd(sched_cmd), .sched_cmd_rdy(sched_cmd_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int              ptr = 0;
  bit              m_val = 1'b0;
  sched_cmd_struct m_cmd = '0;
  int              waits [3] = '{0, 0, 0};

  // per-cycle samples
  bit              s_load;
  int              s_w;
  bit              s_v [3];
  bit              s_merge [3];
  bit              d_rdy [3];
  sched_cmd_struct s_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sched_cmd_struct mk(input logic [FLOWID_W-1:0] fid, input sched_cmd_e dc,
                                         input sched_cmd_e ac, input logic [TIMESTAMP_W-1:0] ats,
                                         input sched_cmd_e rc, input logic [TIMESTAMP_W-1:0] rts);
    sched_cmd_struct c;
    c = '0;
    c.flowid   = fid;
    c.data.cmd = dc;
    c.ack.cmd  = ac;
    c.ack.ts   = ats;
    c.rt.cmd   = rc;
    c.rt.ts    = rts;
    return c;
  endfunction

  task automatic model_reset();
    ptr   = 0;
    m_val = 1'b0;
    waits = '{0, 0, 0};
  endtask

  // Compute the expected grants from the current inputs and compare every DUT output
  task automatic evaluate();
    logic [FLOWID_W-1:0] f [3];
    s_v   = '{data_req_val, ack_req_val, rt_req_val};
    f     = '{data_req_flowid, ack_req_flowid, rt_req_flowid};
    d_rdy = '{data_req_rdy, ack_req_rdy, rt_req_rdy};
    s_load = !m_val || sched_cmd_rdy;
    s_w = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ptr + k) % 3;
      if (s_v[idx] && s_w < 0) s_w = idx;
    end
    for (int i = 0; i < 3; i++) begin
      s_merge[i] = 1'b0;
      if (s_load && s_w >= 0 && s_v[i]) s_merge[i] = (f[i] == f[s_w]);
    end
    if (s_w >= 0)
      s_cmd = mk(f[s_w], s_merge[0] ? SET : NOP,
                 s_merge[1] ? ack_req_cmd : NOP, s_merge[1] ? ack_req_ts : '0,
                 s_merge[2] ? rt_req_cmd : NOP, s_merge[2] ? rt_req_ts : '0);
    chk("data_rdy", {63'd0, data_req_rdy}, {63'd0, s_merge[0]});
    chk("ack_rdy", {63'd0, ack_req_rdy}, {63'd0, s_merge[1]});
    chk("rt_rdy", {63'd0, rt_req_rdy}, {63'd0, s_merge[2]});
    chk("out_val", {63'd0, sched_cmd_val}, {63'd0, m_val});
    if (m_val) chk("out_cmd", 64'(sched_cmd), 64'(m_cmd));
  endtask

  task automatic commit();
    if (s_load) begin
      if (s_w >= 0) begin
        m_val = 1'b1;
        m_cmd = s_cmd;
        ptr   = (s_w + 1) % 3;
      end else begin
        m_val = 1'b0;
      end
    end
    // fairness is measured on the grants the DUT actually issued
    if (d_rdy[0] || d_rdy[1] || d_rdy[2]) begin
      for (int i = 0; i < 3; i++) begin
        if (d_rdy[i]) waits[i] = 0;
        else if (s_v[i]) begin
          waits[i]++;
          chk("fairness_wait", 64'(waits[i] <= 2), 64'd1);
        end
      end
    end
    if (d_rdy[0]) data_req_val = 1'b0;
    if (d_rdy[1]) ack_req_val  = 1'b0;
    if (d_rdy[2]) rt_req_val   = 1'b0;
  endtask

  task automatic cycle();
    #1;
    evaluate();
    @(negedge clk);
    commit();
  endtask

  task automatic rand_inputs();
    if (!data_req_val && $urandom_range(1, 0) == 1) begin
      data_req_val = 1'b1;
      data_req_flowid = FLOWID_W'($urandom_range(3, 0));
    end
    if (!ack_req_val && $urandom_range(1, 0) == 1) begin
      ack_req_val = 1'b1;
      ack_req_flowid = FLOWID_W'($urandom_range(3, 0));
      ack_req_cmd = sched_cmd_e'($urandom_range(2, 0));
      ack_req_ts = TIMESTAMP_W'($urandom);
    end
    if (!rt_req_val && $urandom_range(1, 0) == 1) begin
      rt_req_val = 1'b1;
      rt_req_flowid = FLOWID_W'($urandom_range(3, 0));
      rt_req_cmd = sched_cmd_e'($urandom_range(2, 0));
      rt_req_ts = TIMESTAMP_W'($urandom);
    end
    sched_cmd_rdy = ($urandom_range(3, 0) != 0);
  endtask

  initial begin
    int exp_ids [3];
    data_req_val = 0; data_req_flowid = '0;
    ack_req_val = 0; ack_req_flowid = '0; ack_req_cmd = NOP; ack_req_ts = '0;
    rt_req_val = 0; rt_req_flowid = '0; rt_req_cmd = NOP; rt_req_ts = '0;
    sched_cmd_rdy = 1'b1;
    repeat (2) @(negedge clk);

    // reset state, and no grant while reset is held
    data_req_val = 1'b1; data_req_flowid = 8'd5;
    #1;
    chk("reset_val", {63'd0, sched_cmd_val}, 64'd0);
    chk("reset_cmd", 64'(sched_cmd), 64'd0);
    chk("reset_rdy", {63'd0, data_req_rdy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // lone data request
    #1 chk("t1_rdy", {63'd0, data_req_rdy}, 64'd1);
    cycle();
    chk("t1_val", {63'd0, sched_cmd_val}, 64'd1);
    chk("t1_cmd", 64'(sched_cmd), 64'(mk(8'd5, SET, NOP, 16'h0, NOP, 16'h0)));

    // pointer now at ack: order ack, rt, data
    data_req_val = 1; data_req_flowid = 8'd1;
    ack_req_val = 1; ack_req_flowid = 8'd2; ack_req_cmd = SET; ack_req_ts = 16'h11;
    rt_req_val = 1; rt_req_flowid = 8'd3; rt_req_cmd = CLEAR; rt_req_ts = 16'h22;
    exp_ids = '{2, 3, 1};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rot1_flowid", 64'(sched_cmd.flowid), 64'(exp_ids[i]));
    end
    cycle();
    chk("idle_val", {63'd0, sched_cmd_val}, 64'd0);

    // after reset the pointer restarts at data: order 1, 2, 3
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    data_req_val = 1; data_req_flowid = 8'd1;
    ack_req_val = 1; ack_req_flowid = 8'd2;
    rt_req_val = 1; rt_req_flowid = 8'd3;
    exp_ids = '{1, 2, 3};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rot0_flowid", 64'(sched_cmd.flowid), 64'(exp_ids[i]));
    end

    // data + ack on the same flow merge into one command
    data_req_val = 1; data_req_flowid = 8'd7;
    ack_req_val = 1; ack_req_flowid = 8'd7; ack_req_cmd = SET; ack_req_ts = 16'h40;
    #1;
    chk("merge_data_rdy", {63'd0, data_req_rdy}, 64'd1);
    chk("merge_ack_rdy", {63'd0, ack_req_rdy}, 64'd1);
    cycle();
    chk("merge_cmd", 64'(sched_cmd), 64'(mk(8'd7, SET, SET, 16'h40, NOP, 16'h0)));

    // backpressure holds the output and blocks rt
    data_req_val = 1; data_req_flowid = 8'd10;
    cycle();
    sched_cmd_rdy = 1'b0;
    rt_req_val = 1; rt_req_flowid = 8'd11; rt_req_cmd = CLEAR; rt_req_ts = 16'h55;
    repeat (4) begin
      #1 chk("bp_rt_rdy", {63'd0, rt_req_rdy}, 64'd0);
      cycle();
      chk("bp_hold", 64'(sched_cmd.flowid), 64'd10);
    end
    sched_cmd_rdy = 1'b1;
    #1 chk("bp_release_rdy", {63'd0, rt_req_rdy}, 64'd1);
    cycle();
    chk("bp_load", 64'(sched_cmd), 64'(mk(8'd11, NOP, NOP, 16'h0, CLEAR, 16'h55)));

    // lone ack moves the pointer to rt, then rt+ack merge ahead of data
    ack_req_val = 1; ack_req_flowid = 8'd20; ack_req_cmd = SET; ack_req_ts = 16'h1;
    cycle();
    rt_req_val = 1; rt_req_flowid = 8'd9; rt_req_cmd = CLEAR; rt_req_ts = 16'h1234;
    ack_req_val = 1; ack_req_flowid = 8'd9; ack_req_cmd = SET; ack_req_ts = 16'h77;
    data_req_val = 1; data_req_flowid = 8'd4;
    cycle();
    chk("p2_first", 64'(sched_cmd), 64'(mk(8'd9, NOP, SET, 16'h77, CLEAR, 16'h1234)));
    cycle();
    chk("p2_second", 64'(sched_cmd), 64'(mk(8'd4, SET, NOP, 16'h0, NOP, 16'h0)));

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset while the output holds a command
    for (int n = 0; n < 50 && !m_val; n++) begin
      rand_inputs();
      cycle();
    end
    chk("reset_wait_full", {63'd0, m_val}, 64'd1);
    if (!data_req_val) begin
      data_req_val = 1'b1;
      data_req_flowid = 8'd3;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_val", {63'd0, sched_cmd_val}, 64'd0);
    chk("async_reset_rdy", {63'd0, data_req_rdy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sched_cmd_rdy = 1'b1;
    #1 chk("post_reset_src0", {63'd0, data_req_rdy}, 64'd1);
    cycle();

    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      cycle();
    end
    sched_cmd_rdy = 1'b1;
    repeat (8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
